// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32 five-stage hazard controller.
//   fwd_sel_e   : forwarding mux select driven into the execute-stage muxes
//   mem_state_e : data-memory wait sequencer states
//   LOAD_LAT_*  : legal range of the data-memory load latency parameter
//   CNT_W       : width of the wait down-counter (covers LOAD_LAT_MAX-2)
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_e;

  // Legacy state encodings; the enum below is built on top of them so that
  // older code comparing against raw constants keeps working.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WAIT    = 2'b01;
  localparam logic [1:0] ST_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WAIT    = ST_WAIT,
    RELEASE = ST_RELEASE
  } mem_state_e;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 16;

  localparam int              CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter preload when a load first enters M: LOAD_LAT-2 further wait
  // cycles follow the trigger cycle. Latencies of 1 or 2 need no preload.
  function automatic logic [CNT_W-1:0] cntInit(input int loadLat);
    if (loadLat > 2) begin
      return CNT_W'(loadLat - 2);
    end else begin
      return CNT_ZERO;
    end
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// One-operand forwarding compare for the execute stage. The M-stage result is
// newer than the W-stage result, so an M hit wins. Register x0 never matches.
// Ports:
//   rs        in  REG_AW  source register of the operand in execute
//   rdM       in  REG_AW  destination register in memory stage
//   regWriteM in  1       memory-stage write enable
//   rdW       in  REG_AW  destination register in writeback stage
//   regWriteW in  1       writeback-stage write enable
//   fwdSel    out 2       FWD_NONE / FWD_W / FWD_M
// -----------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regWriteM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteW,
  output fwd_sel_e          fwdSel
);

  logic hitM_s;
  logic hitW_s;

  assign hitM_s = regWriteM && (rdM == rs) && (rs != {REG_AW{1'b0}});
  assign hitW_s = regWriteW && (rdW == rs) && (rs != {REG_AW{1'b0}});

  // Priority select: M result is younger than W result.
  always_comb begin
    fwdSel = FWD_NONE;
    if (hitM_s) begin
      fwdSel = FWD_M;
    end else if (hitW_s) begin
      fwdSel = FWD_W;
    end else begin
      fwdSel = FWD_NONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard controller for the five-stage RV32 pipeline: execute-stage forwarding
// selects, load-use / RAW decode stalls, branch flush and a data-memory wait
// sequencer that freezes the pipe while a slow load sits in M.
//
// Parameters:
//   FWD_EN   1 = forwarding with load-use stall, 0 = stall on any RAW vs E/M
//   LOAD_LAT data-memory load latency in cycles (1..16)
//   REG_AW   register address width
//   PERF_W   performance counter width
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   Rs1D, Rs2D / Rs1E, Rs2E           source registers in decode / execute
//   RD_E, RD_M, RDW                   destinations in E / M / W
//   RegWriteE, RegWriteM, RegWriteW   per-stage write enables
//   ResultSrcE, ResultSrcM            1 = load in that stage
//   PCSrcE                            branch/jump taken in execute
//   ForwardAE, ForwardBE              execute operand forwarding selects
//   StallF, StallD, StallE, StallM    hold stage registers
//   FlushD, FlushE, FlushW            bubble stage registers
//   PerfCycles, PerfStalls, PerfFlushes  performance counters
// Build option:
//   HAZARD_PERF_EN  when defined the performance counters are implemented;
//                   otherwise the counter ports are tied to zero.
// -----------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RDW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              ResultSrcM,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [PERF_W-1:0] PerfCycles,
  output logic [PERF_W-1:0] PerfStalls,
  output logic [PERF_W-1:0] PerfFlushes
);

  // Out-of-range latencies are clamped into the supported window.
  localparam int LAT_EFF = (LOAD_LAT < LOAD_LAT_MIN) ? LOAD_LAT_MIN :
                           (LOAD_LAT > LOAD_LAT_MAX) ? LOAD_LAT_MAX : LOAD_LAT;
  localparam bit               MEM_WAIT_EN = (LAT_EFF > 1);
  localparam logic [CNT_W-1:0] CNT_INIT    = cntInit(LAT_EFF);
  // With a latency of 2 the trigger cycle is the only stall cycle.
  localparam mem_state_e       FIRST_STATE = (LAT_EFF > 2) ? WAIT : RELEASE;
  localparam bit               FWD_ON      = (FWD_EN != 0);

  fwd_sel_e         fwdA_s;
  fwd_sel_e         fwdB_s;
  logic             lwStall_s;
  logic             rawStall_s;
  logic             dStall_s;
  logic             memStall_s;
  mem_state_e       state_r;
  mem_state_e       stateNext_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cntNext_s;

  // True when a writing producer's destination matches a consumer source;
  // x0 is hard-wired zero and never creates a dependency.
  function automatic logic regHit(input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs,
                                  input logic              we);
    return we && (rd == rs) && (rd != {REG_AW{1'b0}});
  endfunction

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .rs        (Rs1E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RDW),
    .regWriteW (RegWriteW),
    .fwdSel    (fwdA_s)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .rs        (Rs2E),
    .rdM       (RD_M),
    .regWriteM (RegWriteM),
    .rdW       (RDW),
    .regWriteW (RegWriteW),
    .fwdSel    (fwdB_s)
  );

  // Decode stall sources. Without forwarding the decode register file is
  // write-first, so only E and M producers can create a RAW hazard.
  always_comb begin
    lwStall_s  = 1'b0;
    rawStall_s = 1'b0;
    if (FWD_ON) begin
      lwStall_s = ResultSrcE &&
                  (regHit(RD_E, Rs1D, RegWriteE) || regHit(RD_E, Rs2D, RegWriteE));
    end else begin
      rawStall_s = regHit(RD_E, Rs1D, RegWriteE) || regHit(RD_E, Rs2D, RegWriteE) ||
                   regHit(RD_M, Rs1D, RegWriteM) || regHit(RD_M, Rs2D, RegWriteM);
    end
  end

  assign dStall_s = lwStall_s || rawStall_s;

  // Memory wait sequencer next state. RELEASE always returns to IDLE so the
  // load still visible in M during its release cycle cannot retrigger.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    memStall_s  = 1'b0;
    if (MEM_WAIT_EN) begin
      case (state_r)
        IDLE: begin
          if (ResultSrcM && RegWriteM) begin
            memStall_s  = 1'b1;
            cntNext_s   = CNT_INIT;
            stateNext_s = FIRST_STATE;
          end else begin
            stateNext_s = IDLE;
          end
        end
        WAIT: begin
          memStall_s = 1'b1;
          cntNext_s  = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            stateNext_s = RELEASE;
          end else begin
            stateNext_s = WAIT;
          end
        end
        RELEASE: begin
          stateNext_s = IDLE;
        end
        default: begin
          stateNext_s = IDLE;
          cntNext_s   = CNT_ZERO;
        end
      endcase
    end else begin
      stateNext_s = IDLE;
      cntNext_s   = CNT_ZERO;
    end
  end

  // Memory wait sequencer state and down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Output priority: memory wait freezes everything and masks the decode
  // stall and branch flushes; a taken branch overrides the decode stall so
  // the target can be fetched. Reset forces every control output low.
  always_comb begin
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (rst) begin
      ForwardAE = FWD_NONE;
      ForwardBE = FWD_NONE;
    end else begin
      if (FWD_ON) begin
        ForwardAE = fwdA_s;
        ForwardBE = fwdB_s;
      end else begin
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
      end
      if (memStall_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (dStall_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        StallF = 1'b0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ZERO = {PERF_W{1'b0}};
  localparam logic [PERF_W-1:0] PERF_ONE  = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] perfCycles_r;
  logic [PERF_W-1:0] perfStalls_r;
  logic [PERF_W-1:0] perfFlushes_r;

  // Free-running performance counters; they wrap naturally at 2^PERF_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfCycles_r  <= PERF_ZERO;
      perfStalls_r  <= PERF_ZERO;
      perfFlushes_r <= PERF_ZERO;
    end else begin
      perfCycles_r <= perfCycles_r + PERF_ONE;
      if (StallF) begin
        perfStalls_r <= perfStalls_r + PERF_ONE;
      end else begin
        perfStalls_r <= perfStalls_r;
      end
      if (FlushE || FlushW) begin
        perfFlushes_r <= perfFlushes_r + PERF_ONE;
      end else begin
        perfFlushes_r <= perfFlushes_r;
      end
    end
  end

  assign PerfCycles  = perfCycles_r;
  assign PerfStalls  = perfStalls_r;
  assign PerfFlushes = perfFlushes_r;
`else
  assign PerfCycles  = {PERF_W{1'b0}};
  assign PerfStalls  = {PERF_W{1'b0}};
  assign PerfFlushes = {PERF_W{1'b0}};
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard controller for the five-stage RV32 pipeline: forwarding select, load-use and RAW stalls, branch flush, plus a multi-cycle data-memory wait sequencer for loads slower than one cycle. Sits beside the pipeline top, observing register addresses and control bits of D/E/M/W and driving stall/flush enables into the fetch/decode/execute/memory stage registers and the forwarding muxes in execute.

## Interface
- FWD_EN, 1: 1 = forwarding + load-use stall; 0 = no forwarding, stall decode on any RAW against E or M
- LOAD_LAT, 1: data-memory load latency in cycles (1..16)
- REG_AW, 5: register address width
- PERF_W, 32: performance counter width
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  REG_AW  source registers in decode
- Rs1E, Rs2E  in  REG_AW  source registers in execute
- RD_E, RD_M, RDW  in  REG_AW  destinations in E/M/W
- RegWriteE, RegWriteM, RegWriteW  in  1  write enables per stage
- ResultSrcE, ResultSrcM  in  1  1 = load in that stage
- PCSrcE  in  1  branch/jump taken in execute
- ForwardAE, ForwardBE  out  2  00 register file, 01 from W, 10 from M
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushW  out  1  insert bubble into stage register
- PerfCycles, PerfStalls, PerfFlushes  out  PERF_W  counters

## Operation
- Register x0 never matches: any compare with address 0 is false.
- Forwarding (FWD_EN=1): ForwardAE=10 if RegWriteM && RD_M==Rs1E; else 01 if RegWriteW && RDW==Rs1E; else 00. ForwardBE same on Rs2E. M beats W. FWD_EN=0: both tied 00.
- Load-use (FWD_EN=1): lw_stall = ResultSrcE && RegWriteE && RD_E∈{Rs1D,Rs2D}.
- RAW (FWD_EN=0): raw_stall = RD_E match (RegWriteE) or RD_M match (RegWriteM) on Rs1D/Rs2D. Decode register file is write-first; no W check.
- d_stall = lw_stall|raw_stall → StallF, StallD, FlushE.
- Branch: PCSrcE → FlushD, FlushE; PCSrcE suppresses d_stall (StallF/StallD low) so the target is fetched.
- Memory wait FSM (active only when LOAD_LAT>1), states IDLE, WAIT, RELEASE, down-counter cnt:
  - IDLE: ResultSrcM && RegWriteM → mem_stall=1; cnt←LOAD_LAT-2; next WAIT if LOAD_LAT>2 else RELEASE.
  - WAIT: mem_stall=1; cnt←cnt-1; next RELEASE when cnt==1.
  - RELEASE: mem_stall=0, load advances to W; next IDLE (no retrigger on the same load).
- mem_stall → StallF, StallD, StallE, StallM, FlushW; highest priority: masks FlushD, FlushE, d_stall. A held branch in E re-resolves in RELEASE.
- LOAD_LAT=1: FSM stays IDLE, mem_stall never asserts.

## Timing
- Forward/stall/flush outputs combinational from inputs and FSM state; FSM, cnt and counters update on rising clk.
- Load entering M at cycle t: stalls asserted cycles t..t+LOAD_LAT-2 (LOAD_LAT-1 cycles); load reaches W at t+LOAD_LAT.
- Load-use: exactly one bubble with FWD_EN=1; with FWD_EN=0, up to two stall cycles per dependent instruction.
- Reset (any time, incl. mid-WAIT): state IDLE, cnt 0, counters 0; with rst high all stall/flush outputs 0, Forward* 00.
- Counters wrap modulo 2^PERF_W.

## Configuration
- HAZARD_PERF_EN defined: PerfCycles +1 every cycle out of reset; PerfStalls +1 per cycle with StallF; PerfFlushes +1 per cycle with FlushE or FlushW.
- Not defined: counter registers absent, the three ports remain and are driven 0.

## Structure
- hazard_pkg: fwd_sel_e (FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10), mem_state_e (IDLE, WAIT, RELEASE), LOAD_LAT bounds constants.
- Sub-module hazard_fwd_sel: one-operand forward compare (Rs, RD_M/RegWriteM, RDW/RegWriteW → fwd_sel_e), instantiated for A and B.

## Test plan
- add x5←x1,x2 in M; sub uses x5 as Rs1E; W writes x5 too → ForwardAE=10; x0 as Rd → 00.
- lw x6 in E, Rs2D=6, FWD_EN=1 → StallF=StallD=FlushE=1 for one cycle, then ForwardBE=01.
- Same with PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0.
- LOAD_LAT=4, lw in M at t → Stall{F,D,E,M}, FlushW high t..t+2, low t+3, FSM IDLE at t+4; back-to-back load retriggers.
- rst asserted mid-WAIT → all outputs 0 asynchronously; after release LOAD_LAT=4 load stalls full 3 cycles.
- HAZARD_PERF_EN, 100 cycles with 3 stall and 2 flush cycles → 100/3/2; undefined → all 0.
